// File: rtl/ad9228_pkg.sv
// ad9228_pkg: shared types and constants for the AD9228 channel emulator
package ad9228_pkg;
  localparam int AD9228_DATA_WIDTH = 12;
  localparam logic [11:0] CHECKER_A = 12'hAAA;
  localparam logic [11:0] CHECKER_B = 12'h555;
  typedef enum logic [1:0] {TM_NORMAL, TM_MIDSCALE, TM_CHECKER, TM_RAMP} test_mode_e;
  typedef enum logic {ST_IDLE, ST_RUN} state_e;
endpackage

// File: rtl/ad9228_pattern_gen.sv
// ad9228_pattern_gen: test-pattern words (midscale, checkerboard, ramp); ports clk, rstn, load, mode in, word out
module ad9228_pattern_gen
  import ad9228_pkg::*;
#(
  parameter int DATA_WIDTH = AD9228_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load,
  input  test_mode_e            mode,
  output logic [DATA_WIDTH-1:0] word
);
  logic                  phase;
  logic [DATA_WIDTH-1:0] ramp;
  logic [DATA_WIDTH-1:0] chk_a;
  test_mode_e            prev;
  logic                  entering;
  // a frame in a different mode than the previous load restarts that mode's sequence
  always_comb begin
    entering = mode != prev;
    chk_a    = {(DATA_WIDTH/2){2'b10}};
    word     = mode == TM_MIDSCALE ? {1'b1, {(DATA_WIDTH-1){1'b0}}} :
               mode == TM_CHECKER  ? ((entering || !phase) ? chk_a : ~chk_a) :
               mode == TM_RAMP     ? (entering ? '0 : ramp) : '0;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      prev  <= TM_NORMAL;
      phase <= 1'b0;
      ramp  <= '0;
    end else if (load) begin
      prev <= mode;
      if (mode == TM_CHECKER) phase <= entering ? 1'b1 : ~phase;
      if (mode == TM_RAMP) ramp <= (entering ? '0 : ramp) + 1'b1;
    end
endmodule

// File: rtl/ad9228_tx_emulator.sv
// ad9228_tx_emulator: AD9228 channel emulator; samples in (s_data/s_valid/s_ready), serial dout/fco/dco out, underrun status
module ad9228_tx_emulator
  import ad9228_pkg::*;
#(
  parameter int DATA_WIDTH     = AD9228_DATA_WIDTH,
  parameter int UNDERRUN_CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      en,
  input  logic [1:0]                test_mode,
  input  logic [DATA_WIDTH-1:0]     s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic                      dout,
  output logic                      fco,
  output logic                      dco,
  output logic                      frame_start,
  output logic                      underrun,
  output logic [UNDERRUN_CNT_W-1:0] underrun_count
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  state_e                state, state_nx;
  test_mode_e            mode;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] sreg, last_word, word, pat_word;
  logic                  last, load, starve;
  ad9228_pattern_gen #(.DATA_WIDTH(DATA_WIDTH)) u_pat (
    .clk  (clk),
    .rstn (rstn),
    .load (load),
    .mode (mode),
    .word (pat_word)
  );
  always_comb begin
    mode     = test_mode_e'(test_mode);
    last     = state == ST_RUN && bit_cnt == LAST;
    load     = en && (state == ST_IDLE || last);
    state_nx = load ? ST_RUN : last ? ST_IDLE : state;
    s_ready  = load && mode == TM_NORMAL;
    starve   = s_ready && !s_valid;
    word     = mode != TM_NORMAL ? pat_word : s_valid ? s_data : last_word;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= ST_IDLE;
    else state <= state_nx;
  // sreg is kept one bit ahead of dout so its MSB is always the next bit to send
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      bit_cnt        <= '0;
      sreg           <= '0;
      last_word      <= '0;
      dout           <= 1'b0;
      fco            <= 1'b0;
      dco            <= 1'b0;
      frame_start    <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      frame_start <= load;
      underrun    <= starve;
      if (starve && !(&underrun_count)) underrun_count <= underrun_count + 1'b1;
      if (s_ready && s_valid) last_word <= s_data;
      if (load) begin
        bit_cnt <= '0;
        sreg    <= {word[DATA_WIDTH-2:0], 1'b0};
        dout    <= word[DATA_WIDTH-1];
        fco     <= 1'b1;
        dco     <= 1'b1;
      end else if (state == ST_RUN && !last) begin
        bit_cnt <= bit_cnt + 1'b1;
        sreg    <= {sreg[DATA_WIDTH-2:0], 1'b0};
        dout    <= sreg[DATA_WIDTH-1];
        fco     <= int'(bit_cnt) + 1 < DATA_WIDTH / 2;
        dco     <= ~dco;
      end else begin
        bit_cnt <= '0;
        dout    <= 1'b0;
        fco     <= 1'b0;
        dco     <= 1'b0;
      end
    end
endmodule

// File: tb/tb_ad9228_tx_emulator.sv
// tb_ad9228_tx_emulator: scoreboard bench for ad9228_tx_emulator
module tb_ad9228_tx_emulator;
  import ad9228_pkg::*;
  localparam int DW = 12;
  typedef struct {
    logic [DW-1:0] word;
    logic          ur;
  } exp_t;
  logic          clk = 1'b0, rstn = 1'b0, en = 1'b0, s_valid = 1'b0;
  logic [1:0]    test_mode = 2'd0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, dout, fco, dco, frame_start, underrun;
  logic [15:0]   underrun_count;
  exp_t          exp_q[$];
  int            n_cmp = 0, n_err = 0;
  logic [DW-1:0] m_last = '0;
  int            m_ur = 0, m_run = 0;
  logic [1:0]    m_prev = 2'd0;
  int            idx = -1;
  logic [DW-1:0] acc = '0;
  always #5 clk = ~clk;
  ad9228_tx_emulator #(.DATA_WIDTH(DW), .UNDERRUN_CNT_W(16)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .en             (en),
    .test_mode      (test_mode),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .dout           (dout),
    .fco            (fco),
    .dco            (dco),
    .frame_start    (frame_start),
    .underrun       (underrun),
    .underrun_count (underrun_count)
  );
  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask
  // Reference: frames since the mode last changed decide checker phase and ramp value
  function automatic exp_t predict(input logic [1:0] mode, input logic valid, input logic [DW-1:0] data);
    exp_t e;
    m_run  = (mode == m_prev) ? m_run + 1 : 0;
    m_prev = mode;
    e.ur   = 1'b0;
    case (mode)
      2'd0: if (valid) begin
          e.word = data;
          m_last = data;
        end else begin
          e.word = m_last;
          e.ur   = 1'b1;
          if (m_ur < 65535) m_ur++;
        end
      2'd1: e.word = 12'h800;
      2'd2: e.word = (m_run % 2 == 1) ? CHECKER_B : CHECKER_A;
      default: e.word = DW'(m_run % 4096);
    endcase
    return e;
  endfunction
  task automatic idle(input int n);
    en = 1'b0;
    s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  // ev_kind: 0 none, 1 drop en, 2 change test_mode, 3 async reset; ev_at = cycle within frame
  task automatic do_frame(input logic [1:0] mode, input logic valid, input logic [DW-1:0] data,
                          input int ev_at, input int ev_kind, input logic [1:0] new_mode);
    en = 1'b1;
    test_mode = mode;
    s_valid = valid;
    s_data = data;
    #1;
    chk("s_ready_at_load", s_ready, mode == 2'd0);
    exp_q.push_back(predict(mode, valid, data));
    for (int i = 1; i <= DW; i++) begin
      @(posedge clk);
      #1;
      if (i == 6) chk("s_ready_mid_frame", s_ready, 0);
      if (i == ev_at) begin
        if (ev_kind == 1) en = 1'b0;
        else if (ev_kind == 2) test_mode = new_mode;
        else if (ev_kind == 3) begin
          rstn = 1'b0;
          en = 1'b0;
          #1;
          chk("reset_lines_async", {dout, fco, dco, frame_start, underrun}, 0);
          chk("reset_ucount_async", underrun_count, 0);
          exp_q.delete();
          m_last = '0;
          m_ur = 0;
          m_run = 0;
          m_prev = 2'd0;
          return;
        end
      end
    end
  endtask
  always @(negedge clk) begin
    if (!rstn) idx = -1;
    else if (frame_start) begin
      chk("frame_start_position", (idx == -1 || idx == DW - 1), 1);
      idx = 0;
      acc = {{(DW-1){1'b0}}, dout};
      if (exp_q.size() == 0) chk("frame_expected", 0, 1);
      else chk("underrun_pulse", underrun, exp_q[0].ur);
      chk("fco_bit0", fco, 1);
      chk("dco_bit0", dco, 1);
    end else if (idx >= 0 && idx < DW - 1) begin
      idx++;
      acc = {acc[DW-2:0], dout};
      chk("fco", fco, idx < DW / 2);
      chk("dco", dco, idx % 2 == 0);
      chk("underrun_quiet", underrun, 0);
      if (idx == DW - 1) begin
        if (exp_q.size() == 0) chk("word_expected", 0, 1);
        else chk("word", acc, exp_q.pop_front().word);
      end
    end else begin
      idx = -1;
      chk("idle_lines", {dout, fco, dco, underrun}, 0);
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_lines", {dout, fco, dco, frame_start, underrun, s_ready}, 0);
    chk("reset_ucount", underrun_count, 0);
    rstn = 1'b1;
    do_frame(2'd0, 1'b1, 12'hABC, 0, 0, 2'd0);
    do_frame(2'd0, 1'b1, 12'h123, 0, 0, 2'd0);
    do_frame(2'd0, 1'b1, 12'h5A5, 0, 0, 2'd0);
    do_frame(2'd0, 1'b0, DW'($urandom), 0, 0, 2'd0);
    do_frame(2'd0, 1'b0, DW'($urandom), 0, 0, 2'd0);
    chk("ucount_two_underruns", underrun_count, 2);
    for (int k = 0; k < 24; k++)
      do_frame(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), DW'($urandom), 0, 0, 2'd0);
    chk("ucount_random", underrun_count, m_ur);
    for (int k = 0; k < 3; k++) do_frame(2'd1, 1'b1, DW'($urandom), 0, 0, 2'd0);
    do_frame(2'd0, 1'b1, DW'($urandom), 0, 0, 2'd0);
    for (int k = 0; k < 3; k++) do_frame(2'd2, 1'b1, DW'($urandom), 0, 0, 2'd0);
    for (int k = 0; k < 4; k++) do_frame(2'd3, 1'b1, DW'($urandom), 0, 0, 2'd0);
    do_frame(2'd1, 1'b1, DW'($urandom), 6, 2, 2'd2);
    do_frame(2'd2, 1'b1, DW'($urandom), 0, 0, 2'd0);
    do_frame(2'd0, 1'b1, DW'($urandom), 4, 1, 2'd0);
    idle(15);
    do_frame(2'd0, 1'b0, DW'($urandom), 8, 3, 2'd0);
    idle(3);
    rstn = 1'b1;
    do_frame(2'd0, 1'b1, DW'($urandom), 0, 0, 2'd0);
    chk("ucount_after_reset", underrun_count, 0);
    for (int k = 0; k < 4100; k++)
      do_frame(2'd3, 1'($urandom_range(0, 1)), DW'($urandom), 0, 0, 2'd0);
    idle(20);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
